frame_ram_arbiter: RTL and testbench

- Shares the single synchronous frame RAM (one read port, one write port, 1-cycle read latency) among several requesters.
- The VGA draw pipeline has absolute read-port priority.
- NUM_CLI game-logic clients (map lookup, pellet clear, sprite update) share reads and writes round-robin.
- Sits between the requesters and the RAM instance and drives its we, write_address, read_address and data_In.

---
 rtl/frame_arb_pkg.sv | 23 ++
 rtl/rr_arbiter.sv | 44 ++++
 rtl/frame_ram_arbiter.sv | 163 ++++++++++++++++
 tb/tb_frame_ram_arbiter.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_arb_pkg.sv
// ============================================================================
// frame_arb_pkg : shared defaults, types and helpers for frame_ram_arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

package frame_arb_pkg;

  localparam int ADDR_W_DEF  = 19;
  localparam int DATA_W_DEF  = 24;
  localparam int NUM_CLI_DEF = 3;

  typedef logic [ADDR_W_DEF-1:0]          addr_t;
  typedef logic [DATA_W_DEF-1:0]          data_t;
  typedef logic [$clog2(NUM_CLI_DEF)-1:0] cli_id_t;

  function automatic int unsigned next_ptr(input int unsigned k, input int unsigned n);
    return (k + 32'd1 >= n) ? 32'd0 : k + 32'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// rr_arbiter : stateless round-robin pick, lowest eligible index at/after i_ptr
// Rev 1.0
// ============================================================================
`default_nettype none

module rr_arbiter #(
  parameter int N   = 3,
  parameter int IDW = $clog2(N)
) (
  input  logic [N-1:0]   i_elig,
  input  logic [IDW-1:0] i_ptr,
  output logic [N-1:0]   o_gnt,
  output logic [IDW-1:0] o_id,
  output logic           o_any
);

  logic [2*N-1:0] w_dbl;
  logic [2*N-1:0] w_mask;
  logic [2*N-1:0] w_req;
  int             w_sel;
  int             w_idx;

  // Upper copy is fully unmasked, so the search wraps past i_ptr naturally.
  always_comb begin
    w_dbl  = {i_elig, i_elig};
    w_mask = ~(((2*N)'(1) << i_ptr) - (2*N)'(1));
    w_req  = w_dbl & w_mask;
    w_sel  = 0;
    o_any  = 1'b0;
    for (int i = 2*N-1; i >= 0; i--) begin
      if (w_req[i]) begin
        w_sel = i;
        o_any = 1'b1;
      end
    end
    w_idx = (w_sel >= N) ? (w_sel - N) : w_sel;
    o_id  = o_any ? IDW'(w_idx) : '0;
    o_gnt = o_any ? (N'(1) << o_id) : '0;
  end

endmodule

`default_nettype wire

// File: rtl/frame_ram_arbiter.sv
// ============================================================================
// frame_ram_arbiter : frame RAM port sharing, draw read priority + RR clients
// Optional same-cycle write->read forwarding: define FRAME_ARB_FWD_EN.
// Rev 1.0
// ============================================================================
`default_nettype none

module frame_ram_arbiter
  import frame_arb_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int NUM_CLI    = NUM_CLI_DEF,
  parameter int STARVE_LIM = 255
) (
  input  logic                        Clk,
  input  logic                        Reset_n,
  input  logic                        draw_req,
  input  logic [ADDR_W-1:0]           draw_addr,
  output logic                        draw_valid,
  output logic [DATA_W-1:0]           draw_data,
  input  logic [NUM_CLI-1:0]          cli_req,
  input  logic [NUM_CLI-1:0]          cli_we,
  input  logic [NUM_CLI*ADDR_W-1:0]   cli_addr,
  input  logic [NUM_CLI*DATA_W-1:0]   cli_wdata,
  output logic [NUM_CLI-1:0]          cli_gnt,
  output logic                        cli_rvalid,
  output logic [$clog2(NUM_CLI)-1:0]  cli_rid,
  output logic [DATA_W-1:0]           cli_rdata,
  output logic [NUM_CLI-1:0]          starve,
  output logic                        ram_we,
  output logic [ADDR_W-1:0]           ram_write_address,
  output logic [ADDR_W-1:0]           ram_read_address,
  output logic [DATA_W-1:0]           ram_data_In,
  input  logic [DATA_W-1:0]           ram_data_Out
);

  localparam int IDW   = $clog2(NUM_CLI);
  localparam int CNT_W = $clog2(STARVE_LIM + 1);
  localparam logic [CNT_W-1:0] LIM    = CNT_W'(STARVE_LIM);
  localparam logic [CNT_W-1:0] LIM_M1 = CNT_W'(STARVE_LIM - 1);

  logic [IDW-1:0]     r_rr_ptr;
  logic               r_draw_p;
  logic               r_crd_p;
  logic [IDW-1:0]     r_rid_p;
  logic [CNT_W-1:0]   r_cnt [NUM_CLI];
  logic [NUM_CLI-1:0] r_starve;

  logic               w_draw;
  logic [NUM_CLI-1:0] w_elig;
  logic [NUM_CLI-1:0] w_gnt;
  logic [IDW-1:0]     w_win_id;
  logic               w_any;
  logic               w_win_we;
  logic [ADDR_W-1:0]  w_win_addr;
  logic [DATA_W-1:0]  w_win_wdata;
  logic               w_gnt_wr;
  logic               w_gnt_rd;
  logic [DATA_W-1:0]  w_rdata;

  // Gating with Reset_n forces every combinational output low during reset.
  assign w_draw = draw_req & Reset_n;
  assign w_elig = cli_req & (cli_we | {NUM_CLI{~draw_req}}) & {NUM_CLI{Reset_n}};

  rr_arbiter #(
    .N   (NUM_CLI),
    .IDW (IDW)
  ) u_rr (
    .i_elig (w_elig),
    .i_ptr  (r_rr_ptr),
    .o_gnt  (w_gnt),
    .o_id   (w_win_id),
    .o_any  (w_any)
  );

  always_comb begin
    w_win_we    = 1'b0;
    w_win_addr  = '0;
    w_win_wdata = '0;
    for (int k = 0; k < NUM_CLI; k++) begin
      if (w_win_id == IDW'(k)) begin
        w_win_we    = cli_we[k];
        w_win_addr  = cli_addr[k*ADDR_W +: ADDR_W];
        w_win_wdata = cli_wdata[k*DATA_W +: DATA_W];
      end
    end
  end

  assign w_gnt_wr = w_any & w_win_we;
  assign w_gnt_rd = w_any & ~w_win_we;

  assign cli_gnt           = w_gnt;
  assign ram_we            = w_gnt_wr;
  assign ram_write_address = w_gnt_wr ? w_win_addr : '0;
  assign ram_data_In       = w_gnt_wr ? w_win_wdata : '0;
  assign ram_read_address  = w_draw ? draw_addr : (w_gnt_rd ? w_win_addr : '0);

`ifdef FRAME_ARB_FWD_EN
  logic              r_fwd_v;
  logic [DATA_W-1:0] r_fwd_data;
  logic              w_fwd_hit;

  // Only one client wins per cycle, so a read beside a write is always draw.
  assign w_fwd_hit = w_gnt_wr & (w_draw | w_gnt_rd) & (w_win_addr == ram_read_address);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_fwd_v    <= 1'b0;
      r_fwd_data <= '0;
    end else begin
      r_fwd_v <= w_fwd_hit;
      if (w_fwd_hit) r_fwd_data <= w_win_wdata;
    end
  end

  assign w_rdata = r_fwd_v ? r_fwd_data : ram_data_Out;
`else
  assign w_rdata = ram_data_Out;
`endif

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_rr_ptr <= '0;
      r_draw_p <= 1'b0;
      r_crd_p  <= 1'b0;
      r_rid_p  <= '0;
    end else begin
      r_draw_p <= w_draw;
      r_crd_p  <= w_gnt_rd;
      r_rid_p  <= w_gnt_rd ? w_win_id : '0;
      if (w_any) r_rr_ptr <= IDW'(next_ptr(32'(w_win_id), NUM_CLI));
    end
  end

  // Starvation tracks only reads blocked by draw; starve sets as count hits LIM.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int k = 0; k < NUM_CLI; k++) r_cnt[k] <= '0;
      r_starve <= '0;
    end else begin
      for (int k = 0; k < NUM_CLI; k++) begin
        if (w_gnt[k] || !cli_req[k]) begin
          r_cnt[k] <= '0;
        end else if (!cli_we[k] && draw_req) begin
          if (r_cnt[k] != LIM) r_cnt[k] <= r_cnt[k] + 1'b1;
          if (r_cnt[k] >= LIM_M1) r_starve[k] <= 1'b1;
        end
        if (w_gnt[k]) r_starve[k] <= 1'b0;
      end
    end
  end

  assign starve     = r_starve;
  assign draw_valid = r_draw_p;
  assign cli_rvalid = r_crd_p;
  assign cli_rid    = r_rid_p;
  assign draw_data  = r_draw_p ? w_rdata : '0;
  assign cli_rdata  = r_crd_p ? w_rdata : '0;

endmodule

`default_nettype wire

// File: tb/tb_frame_ram_arbiter.sv
// ============================================================================
// tb_frame_ram_arbiter : directed self-checking bench with a read-before-write RAM
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_frame_ram_arbiter;

  localparam int AW = 19;
  localparam int DW = 24;
  localparam int NC = 3;

  logic             Clk;
  logic             Reset_n;
  logic             draw_req;
  logic [AW-1:0]    draw_addr;
  logic             draw_valid;
  logic [DW-1:0]    draw_data;
  logic [NC-1:0]    cli_req;
  logic [NC-1:0]    cli_we;
  logic [NC*AW-1:0] cli_addr;
  logic [NC*DW-1:0] cli_wdata;
  logic [NC-1:0]    cli_gnt;
  logic             cli_rvalid;
  logic [1:0]       cli_rid;
  logic [DW-1:0]    cli_rdata;
  logic [NC-1:0]    starve;
  logic             ram_we;
  logic [AW-1:0]    ram_write_address;
  logic [AW-1:0]    ram_read_address;
  logic [DW-1:0]    ram_data_In;
  logic [DW-1:0]    ram_data_Out;

  int n_checks = 0;
  int n_pass   = 0;

  frame_ram_arbiter dut (
    .Clk               (Clk),
    .Reset_n           (Reset_n),
    .draw_req          (draw_req),
    .draw_addr         (draw_addr),
    .draw_valid        (draw_valid),
    .draw_data         (draw_data),
    .cli_req           (cli_req),
    .cli_we            (cli_we),
    .cli_addr          (cli_addr),
    .cli_wdata         (cli_wdata),
    .cli_gnt           (cli_gnt),
    .cli_rvalid        (cli_rvalid),
    .cli_rid           (cli_rid),
    .cli_rdata         (cli_rdata),
    .starve            (starve),
    .ram_we            (ram_we),
    .ram_write_address (ram_write_address),
    .ram_read_address  (ram_read_address),
    .ram_data_In       (ram_data_In),
    .ram_data_Out      (ram_data_Out)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Unwritten locations read back as 0xA00000 | addr[7:0].
  bit [DW-1:0] mem [256];
  bit          written [256];
  always @(posedge Clk) begin
    if (ram_we) begin
      mem[ram_write_address[7:0]]     <= ram_data_In;
      written[ram_write_address[7:0]] <= 1'b1;
    end
    ram_data_Out <= written[ram_read_address[7:0]] ? mem[ram_read_address[7:0]]
                                                   : (24'hA00000 | {16'h0, ram_read_address[7:0]});
  end

  task automatic idle_inputs();
    draw_req  = 1'b0;
    draw_addr = '0;
    cli_req   = '0;
    cli_we    = '0;
    cli_addr  = '0;
    cli_wdata = '0;
  endtask

  task automatic set_cli(input int k, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    cli_req[k]             = 1'b1;
    cli_we[k]              = we;
    cli_addr[k*AW +: AW]   = a;
    cli_wdata[k*DW +: DW]  = d;
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    Reset_n = 1'b0;
    idle_inputs();
    draw_req = 1'b1;
    draw_addr = 19'h7;
    set_cli(0, 1'b0, 19'h1, 24'h0);
    set_cli(2, 1'b1, 19'h2, 24'h55AA55);
    @(negedge Clk); @(negedge Clk); #1;
    n_checks++; if (cli_gnt !== 3'b000) $display("FAIL rst_gnt: got %b want 000", cli_gnt); else n_pass++;
    n_checks++; if (ram_we !== 1'b0) $display("FAIL rst_we: got %b want 0", ram_we); else n_pass++;
    n_checks++; if (ram_read_address !== 19'h0) $display("FAIL rst_raddr: got %h want 0", ram_read_address); else n_pass++;
    n_checks++; if (ram_write_address !== 19'h0) $display("FAIL rst_waddr: got %h want 0", ram_write_address); else n_pass++;
    n_checks++; if (ram_data_In !== 24'h0) $display("FAIL rst_wdata: got %h want 0", ram_data_In); else n_pass++;
    n_checks++; if (draw_valid !== 1'b0) $display("FAIL rst_dvalid: got %b want 0", draw_valid); else n_pass++;
    n_checks++; if (cli_rvalid !== 1'b0) $display("FAIL rst_rvalid: got %b want 0", cli_rvalid); else n_pass++;
    n_checks++; if (starve !== 3'b000) $display("FAIL rst_starve: got %b want 000", starve); else n_pass++;
    @(negedge Clk);
    idle_inputs();
    Reset_n = 1'b1;
    tick();
  endtask

  task automatic test_client_read();
    @(negedge Clk);
    set_cli(1, 1'b0, 19'h00010, 24'h0);
    #1;
    n_checks++; if (cli_gnt !== 3'b010) $display("FAIL cr_gnt: got %b want 010", cli_gnt); else n_pass++;
    n_checks++; if (ram_read_address !== 19'h10) $display("FAIL cr_raddr: got %h want 10", ram_read_address); else n_pass++;
    tick();
    n_checks++; if (cli_rvalid !== 1'b1) $display("FAIL cr_rvalid: got %b want 1", cli_rvalid); else n_pass++;
    n_checks++; if (cli_rid !== 2'd1) $display("FAIL cr_rid: got %0d want 1", cli_rid); else n_pass++;
    n_checks++; if (cli_rdata !== 24'hA00010) $display("FAIL cr_rdata: got %h want a00010", cli_rdata); else n_pass++;
    n_checks++; if (draw_valid !== 1'b0) $display("FAIL cr_dvalid: got %b want 0", draw_valid); else n_pass++;
    @(negedge Clk);
    idle_inputs();
    tick();
    n_checks++; if (cli_rvalid !== 1'b0) $display("FAIL cr_rvalid_drop: got %b want 0", cli_rvalid); else n_pass++;
  endtask

  task automatic test_draw_stream();
    @(negedge Clk);
    set_cli(0, 1'b0, 19'h00005, 24'h0);
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge Clk);
      draw_req  = 1'b1;
      draw_addr = AW'(i);
      #1;
      n_checks++; if (cli_gnt !== 3'b000) $display("FAIL ds_gnt[%0d]: got %b want 000", i, cli_gnt); else n_pass++;
      tick();
      n_checks++; if (draw_valid !== 1'b1) $display("FAIL ds_dvalid[%0d]: got %b want 1", i, draw_valid); else n_pass++;
      n_checks++; if (draw_data !== (24'hA00000 + 24'(i))) $display("FAIL ds_ddata[%0d]: got %h want %h", i, draw_data, 24'hA00000 + 24'(i)); else n_pass++;
    end
    for (int j = 0; j < 244; j++) tick();
    n_checks++; if (starve !== 3'b000) $display("FAIL ds_starve254: got %b want 000", starve); else n_pass++;
    tick();
    n_checks++; if (starve !== 3'b001) $display("FAIL ds_starve255: got %b want 001", starve); else n_pass++;
    @(negedge Clk);
    draw_req = 1'b0;
    #1;
    n_checks++; if (cli_gnt !== 3'b001) $display("FAIL ds_gnt_release: got %b want 001", cli_gnt); else n_pass++;
    tick();
    n_checks++; if (starve !== 3'b000) $display("FAIL ds_starve_clr: got %b want 000", starve); else n_pass++;
    n_checks++; if (cli_rvalid !== 1'b1) $display("FAIL ds_rvalid: got %b want 1", cli_rvalid); else n_pass++;
    n_checks++; if (cli_rid !== 2'd0) $display("FAIL ds_rid: got %0d want 0", cli_rid); else n_pass++;
    n_checks++; if (cli_rdata !== 24'hA00005) $display("FAIL ds_rdata: got %h want a00005", cli_rdata); else n_pass++;
    n_checks++; if (draw_valid !== 1'b0) $display("FAIL ds_dvalid_end: got %b want 0", draw_valid); else n_pass++;
    @(negedge Clk);
    idle_inputs();
  endtask

  task automatic test_write_during_draw();
    @(negedge Clk);
    draw_req  = 1'b1;
    draw_addr = 19'h20;
    set_cli(2, 1'b1, 19'h30, 24'hABCDEF);
    #1;
    n_checks++; if (cli_gnt !== 3'b100) $display("FAIL wd_gnt: got %b want 100", cli_gnt); else n_pass++;
    n_checks++; if (ram_we !== 1'b1) $display("FAIL wd_we: got %b want 1", ram_we); else n_pass++;
    n_checks++; if (ram_write_address !== 19'h30) $display("FAIL wd_waddr: got %h want 30", ram_write_address); else n_pass++;
    n_checks++; if (ram_data_In !== 24'hABCDEF) $display("FAIL wd_wdata: got %h want abcdef", ram_data_In); else n_pass++;
    n_checks++; if (ram_read_address !== 19'h20) $display("FAIL wd_raddr: got %h want 20", ram_read_address); else n_pass++;
    tick();
    n_checks++; if (draw_data !== 24'hA00020) $display("FAIL wd_ddata: got %h want a00020", draw_data); else n_pass++;
    n_checks++; if (cli_rvalid !== 1'b0) $display("FAIL wd_rvalid: got %b want 0", cli_rvalid); else n_pass++;
    @(negedge Clk);
    idle_inputs();
    set_cli(0, 1'b0, 19'h30, 24'h0);
    #1;
    n_checks++; if (cli_gnt !== 3'b001) $display("FAIL wd_rd_gnt: got %b want 001", cli_gnt); else n_pass++;
    tick();
    n_checks++; if (cli_rdata !== 24'hABCDEF) $display("FAIL wd_readback: got %h want abcdef", cli_rdata); else n_pass++;
    @(negedge Clk);
    idle_inputs();
  endtask

  task automatic test_reset_inflight();
    @(negedge Clk);
    set_cli(1, 1'b0, 19'h11, 24'h0);
    #1;
    n_checks++; if (cli_gnt !== 3'b010) $display("FAIL ri_gnt: got %b want 010", cli_gnt); else n_pass++;
    @(posedge Clk);
    #1;
    Reset_n = 1'b0;
    #1;
    n_checks++; if (cli_rvalid !== 1'b0) $display("FAIL ri_rvalid_rst: got %b want 0", cli_rvalid); else n_pass++;
    n_checks++; if (cli_rdata !== 24'h0) $display("FAIL ri_rdata_rst: got %h want 0", cli_rdata); else n_pass++;
    n_checks++; if (cli_gnt !== 3'b000) $display("FAIL ri_gnt_rst: got %b want 000", cli_gnt); else n_pass++;
    @(negedge Clk);
    idle_inputs();
    Reset_n = 1'b1;
    tick();
    n_checks++; if (cli_rvalid !== 1'b0) $display("FAIL ri_rvalid_post: got %b want 0", cli_rvalid); else n_pass++;
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_g [4];
    logic [1:0] exp_id [4];
    exp_g  = '{3'b001, 3'b010, 3'b100, 3'b001};
    exp_id = '{2'd0, 2'd1, 2'd2, 2'd0};
    @(negedge Clk);
    set_cli(0, 1'b0, 19'h50, 24'h0);
    set_cli(1, 1'b0, 19'h51, 24'h0);
    set_cli(2, 1'b0, 19'h52, 24'h0);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge Clk);
      #1;
      n_checks++; if (cli_gnt !== exp_g[i]) $display("FAIL rr_gnt[%0d]: got %b want %b", i, cli_gnt, exp_g[i]); else n_pass++;
      tick();
      n_checks++; if (cli_rid !== exp_id[i]) $display("FAIL rr_rid[%0d]: got %0d want %0d", i, cli_rid, exp_id[i]); else n_pass++;
      n_checks++; if (cli_rdata !== (24'hA00050 + 24'(exp_id[i]))) $display("FAIL rr_rdata[%0d]: got %h want %h", i, cli_rdata, 24'hA00050 + 24'(exp_id[i])); else n_pass++;
    end
    @(negedge Clk);
    idle_inputs();
  endtask

  task automatic test_same_addr();
    logic [DW-1:0] exp_d;
`ifdef FRAME_ARB_FWD_EN
    exp_d = 24'h123456;
`else
    exp_d = 24'hA00040;
`endif
    @(negedge Clk);
    draw_req  = 1'b1;
    draw_addr = 19'h40;
    set_cli(2, 1'b1, 19'h40, 24'h123456);
    #1;
    n_checks++; if (cli_gnt !== 3'b100) $display("FAIL sa_gnt: got %b want 100", cli_gnt); else n_pass++;
    tick();
    n_checks++; if (draw_data !== exp_d) $display("FAIL sa_ddata: got %h want %h", draw_data, exp_d); else n_pass++;
    @(negedge Clk);
    cli_req = '0;
    cli_we  = '0;
    tick();
    n_checks++; if (draw_data !== 24'h123456) $display("FAIL sa_ddata_next: got %h want 123456", draw_data); else n_pass++;
    @(negedge Clk);
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_client_read();
    test_draw_stream();
    test_write_during_draw();
    test_reset_inflight();
    test_round_robin();
    test_same_addr();
    tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
